// File: rtl/gcd_result_queue.sv
// Circular result FIFO placed after gcd_coprocessor, with val/rdy on both sides.
// Optional GCD_RESULT_QUEUE_TAG_EN adds an 8-bit enqueue sequence tag per entry.
module gcd_result_queue #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_val,
    input  logic [W-1:0]               in_bits,
    output logic                       in_rdy,
    output logic                       out_val,
    output logic [W-1:0]               out_bits,
    input  logic                       out_rdy,
`ifdef GCD_RESULT_QUEUE_TAG_EN
    output logic [7:0]                 out_tag,
`endif
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
`ifdef GCD_RESULT_QUEUE_TAG_EN
    localparam int SW = W + 8;
`else
    localparam int SW = W;
`endif
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [SW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic [SW-1:0] entry_d;
    logic          enq;
    logic          deq;

    // Handshake readiness comes from registered occupancy only.
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign in_rdy  = ~full;
    assign out_val = ~empty;
    assign count   = count_q;

    assign enq = in_val & in_rdy;
    assign deq = out_val & out_rdy;

`ifdef GCD_RESULT_QUEUE_TAG_EN
    logic [7:0] tag_cnt_q, tag_cnt_d;

    assign entry_d   = {tag_cnt_q, in_bits};
    assign tag_cnt_d = enq ? tag_cnt_q + 8'd1 : tag_cnt_q;
    assign out_tag   = mem_q[rp_q][W +: 8];

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_cnt_q <= 8'd0;
        end else begin
            tag_cnt_q <= tag_cnt_d;
        end
    end
`else
    assign entry_d = in_bits;
`endif

    assign out_bits = mem_q[rp_q][W-1:0];

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (enq) begin
            wp_d = wp_q + 1'b1;
        end
        if (deq) begin
            rp_d = rp_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Entries are cleared on reset so the head never reads as X.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!reset) begin
                    mem_q[gi] <= '0;
                end else if (enq && (wp_q == AW'(gi))) begin
                    mem_q[gi] <= entry_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_gcd_result_queue.sv
// Directed bench for gcd_result_queue: reset, single pass, fill/block,
// simultaneous enq/deq, wrap-around streaming and mid-stream reset.
module tb_gcd_result_queue;

    logic        clk;
    logic        reset;
    logic        in_val;
    logic [15:0] in_bits;
    logic        in_rdy;
    logic        out_val;
    logic [15:0] out_bits;
    logic        out_rdy;
    logic [2:0]  count;
    logic        full;
    logic        empty;
`ifdef GCD_RESULT_QUEUE_TAG_EN
    logic [7:0]  out_tag;
`endif

    int total = 0;
    int bad   = 0;

    gcd_result_queue #(.W(16), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_bits  (in_bits),
        .in_rdy   (in_rdy),
        .out_val  (out_val),
        .out_bits (out_bits),
        .out_rdy  (out_rdy),
`ifdef GCD_RESULT_QUEUE_TAG_EN
        .out_tag  (out_tag),
`endif
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  next_in;
        int  exp_out;
        int  mcnt;
        int  cyc;
        bit  menq;
        bit  mdeq;

        reset   = 1'b0;
        in_val  = 1'b0;
        in_bits = 16'd0;
        out_rdy = 1'b0;
        repeat (5) tick();
        reset = 1'b1;

        // Reset state
        chk("rst_in_rdy",   in_rdy,   1);
        chk("rst_out_val",  out_val,  0);
        chk("rst_count",    count,    0);
        chk("rst_empty",    empty,    1);
        chk("rst_full",     full,     0);
        chk("rst_out_bits", out_bits, 0);
`ifdef GCD_RESULT_QUEUE_TAG_EN
        chk("rst_out_tag",  out_tag,  0);
`endif
        tick();

        // Single pass
        in_val = 1'b1; in_bits = 16'd7; out_rdy = 1'b1;
        tick();
        in_val = 1'b0;
        chk("sp_out_val",  out_val,  1);
        chk("sp_out_bits", out_bits, 7);
        chk("sp_count1",   count,    1);
        tick();
        chk("sp_count0",   count,    0);
        chk("sp_empty",    empty,    1);

        // Fill and block
        out_rdy = 1'b0;
        in_val = 1'b1; in_bits = 16'd7; tick();
        in_bits = 16'd4; tick();
        in_bits = 16'd5; tick();
        chk("fill_count3", count, 3);
        chk("fill_full3",  full,  0);
        in_bits = 16'd3; tick();
        chk("fill_full",   full,   1);
        chk("fill_in_rdy", in_rdy, 0);
        chk("fill_count4", count,  4);
        in_bits = 16'd9; tick();
        chk("blk_count",    count,    4);
        chk("blk_head",     out_bits, 7);
        chk("blk_in_rdy",   in_rdy,   0);
        out_rdy = 1'b1;
        tick();
        chk("drain1_count", count,    3);
        chk("drain1_inrdy", in_rdy,   1);
        chk("drain1_head",  out_bits, 4);
        tick();
        in_val = 1'b0;
        chk("drain2_count", count,    3);
        chk("drain2_head",  out_bits, 5);
        tick();
        chk("drain3_head",  out_bits, 3);
        chk("drain3_count", count,    2);
        tick();
        chk("drain4_head",  out_bits, 9);
        chk("drain4_count", count,    1);
        tick();
        chk("drain5_count", count,    0);
        chk("drain5_oval",  out_val,  0);

        // Simultaneous enqueue/dequeue at count 2
        out_rdy = 1'b0;
        in_val = 1'b1; in_bits = 16'd20; tick();
        in_bits = 16'd21; tick();
        chk("sim_pre_count", count,    2);
        chk("sim_pre_head",  out_bits, 20);
        out_rdy = 1'b1;
        in_bits = 16'd22; tick();
        chk("sim1_count", count,    2);
        chk("sim1_head",  out_bits, 21);
        in_bits = 16'd23; tick();
        chk("sim2_count", count,    2);
        chk("sim2_head",  out_bits, 22);
        in_val = 1'b0;
        tick();
        chk("sim3_head",  out_bits, 23);
        chk("sim3_count", count,    1);
        tick();
        chk("sim4_count", count,    0);

        // Wrap-around: stream 1..10, out_rdy toggles every cycle
        next_in = 1;
        exp_out = 1;
        mcnt    = 0;
        cyc     = 0;
        while (exp_out <= 10 && cyc < 200) begin
            out_rdy = cyc[0];
            in_val  = (next_in <= 10);
            in_bits = next_in[15:0];
            chk("wrap_count",   count,   mcnt);
            chk("wrap_in_rdy",  in_rdy,  (mcnt != 4));
            chk("wrap_out_val", out_val, (mcnt != 0));
            menq = in_val && (mcnt != 4);
            mdeq = (mcnt != 0) && out_rdy;
            if (mdeq) begin
                chk("wrap_data", out_bits, exp_out);
                exp_out++;
            end
            if (menq) next_in++;
            mcnt = mcnt + int'(menq) - int'(mdeq);
            tick();
            cyc++;
        end
        in_val  = 1'b0;
        out_rdy = 1'b0;
        chk("wrap_all_out", exp_out, 11);
        chk("wrap_end_cnt", count,   0);

        // Mid-stream reset with 3 entries queued
        in_val = 1'b1; in_bits = 16'd31; tick();
        in_bits = 16'd32; tick();
        in_bits = 16'd33; tick();
        in_val = 1'b0;
        chk("mr_pre_count", count, 3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mr_count",    count,    0);
        chk("mr_out_val",  out_val,  0);
        chk("mr_in_rdy",   in_rdy,   1);
        chk("mr_out_bits", out_bits, 0);
`ifdef GCD_RESULT_QUEUE_TAG_EN
        chk("mr_out_tag",  out_tag,  0);
`endif
        in_val = 1'b1; in_bits = 16'd44; tick();
        in_val = 1'b0;
        chk("mr_post_head",  out_bits, 44);
        chk("mr_post_count", count,    1);
`ifdef GCD_RESULT_QUEUE_TAG_EN
        chk("mr_post_tag",   out_tag,  0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcd_result_queue.md
# gcd_result_queue

Result buffer sitting directly downstream of `gcd_coprocessor`. It accepts 16-bit GCD results over a val/rdy handshake and stores them in a circular FIFO. It presents them in order to a consumer (host bus or test sink) over a second val/rdy handshake. This decouples coprocessor throughput from consumer stalls, so `result_rdy` no longer has to be tied high.

## Interface
Parameters:
- `W`, 16, result data width; matches the coprocessor width parameter.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `AW`, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `in_val`  in  1  result valid; connects to the coprocessor `result_val`.
- `in_bits`  in  W  result data; connects to `result_bits`.
- `in_rdy`  out  1  queue can accept; connects to `result_rdy`.
- `out_val`  out  1  head entry valid.
- `out_bits`  out  W  head entry data.
- `out_rdy`  in  1  consumer accepts head.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.

## Operation
- Storage is a DEPTH×W register array, with write pointer `wp`, read pointer `rp` and occupancy `count`.
- Enqueue fires when `in_val && in_rdy`:
  - `mem[wp] <= in_bits`
  - `wp <= wp + 1`, mod DEPTH
- Dequeue fires when `out_val && out_rdy`: `rp <= rp + 1`, mod DEPTH.
- Count update per cycle:
  - enqueue only: +1
  - dequeue only: −1
  - both or neither: unchanged
- Pointers wrap naturally at DEPTH; `count` alone distinguishes full from empty.
- Outputs:
  - `in_rdy = ~full`. Depends on registered state only; there is no combinational path from `out_rdy`.
  - `out_val = ~empty`.
  - `out_bits = mem[rp]`. Value is don't-care when empty but must not be X after reset, so the array is cleared on reset.
- Boundary cases:
  - Full with `out_rdy` high: dequeue occurs, enqueue is blocked this cycle, and `in_rdy` rises the next cycle.
  - Empty with `in_val` high: enqueue occurs; no dequeue is possible that cycle because there is no fall-through.
  - Simultaneous enqueue and dequeue at partial occupancy: both pointers advance and `count` holds.
  - `in_val` while full: ignored, and the data is not stored. The producer must hold the value per the val/rdy contract.
- Reset (`reset == 0` at a clock edge):
  - `wp`, `rp` and `count` go to 0, and `mem` is cleared to 0.
  - Any in-flight contents are discarded, including during a mid-stream reset.

## Timing
- Reset values: `in_rdy = 1`, `out_val = 0`, `out_bits = 0`, `count = 0`, `full = 0`, `empty = 1`, `out_tag = 0` (when present).
- Latency is 1 cycle: an entry enqueued at edge N is visible with `out_val = 1` after edge N.
- Throughput is 1 entry/cycle sustained in both directions when 0 < `count` < DEPTH.
- `out_bits` and `out_val` must stay stable while `out_val && ~out_rdy`.

## Configuration
- Macro `GCD_RESULT_QUEUE_TAG_EN`.
- When defined:
  - Adds output port `out_tag` [7:0] and an 8-bit accept counter `tag_cnt`, reset to 0, incremented on each enqueue and wrapping 255→0.
  - Each entry stores `{tag_cnt, in_bits}`, so `out_tag` gives the enqueue sequence number of the head entry, letting the consumer detect dropped or reordered results.
- When undefined: no `out_tag` port, no counter, and the storage width is exactly W.

## Test plan
- Reset then idle: `reset = 0` for 5 cycles, then release -> `in_rdy = 1`, `out_val = 0`, `count = 0`, `empty = 1`.
- Single pass: enqueue 7 with `out_rdy = 1` -> the next cycle shows `out_val = 1`, `out_bits = 7`; the cycle after shows `count = 0`.
- Fill and block: `out_rdy = 0`, enqueue 7, 4, 5, 3, 9 -> `full = 1` after the 4th, `in_rdy = 0`, and 9 is not accepted. Then set `out_rdy = 1` -> outputs 7, 4, 5, 3 in order, and 9 is accepted the cycle after the first dequeue.
- Wrap-around: stream 10 results (1..10) with `out_rdy` toggling every cycle -> all 10 emerge in order, `count` never exceeds 4, and the pointers wrap at least twice.
- Simultaneous enqueue/dequeue at `count = 2`: `count` stays 2 and the head advances correctly.
- Mid-stream reset: with 3 entries queued, assert `reset = 0` for 1 cycle -> `count = 0`, `out_val = 0`, and `out_tag` restarts at 0 when `GCD_RESULT_QUEUE_TAG_EN` is set.
